// File: rtl/spi_master.sv
// Single-channel SPI master, mode 0, MSB first, 16-bit transactions with a 5-way slave select.
// Optional SPI_WRT_ERR_EN adds wrt_err, a pulse flagging a wrt request seen while busy.
module spi_master #(
   parameter int unsigned SCLK_DIV = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wrt,
   input  logic [15:0] cmd,
   input  logic [2:0]  ss_sel,
   input  logic        MISO,
   output logic        SCLK,
   output logic        MOSI,
   output logic [4:0]  SS_n,
   output logic        done,
   output logic [7:0]  rd_data
`ifdef SPI_WRT_ERR_EN
   ,
   output logic        wrt_err
`endif
);

   localparam int unsigned H     = SCLK_DIV / 2;
   localparam int unsigned CNT_W = $clog2(SCLK_DIV);

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(H - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(SCLK_DIV - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FRONT = 2'd1;
   localparam logic [1:0] XFER  = 2'd2;
   localparam logic [1:0] BACK  = 2'd3;

   localparam logic [2:0] SS_NONE    = 3'd0;
   localparam logic [2:0] SS_CH1     = 3'd1;
   localparam logic [2:0] SS_CH2     = 3'd2;
   localparam logic [2:0] SS_CH3     = 3'd3;
   localparam logic [2:0] SS_TRIGGER = 3'd4;
   localparam logic [2:0] SS_EEPROM  = 3'd5;

   logic [1:0]       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [3:0]       bit_cnt, bit_cnt_nxt;
   logic [15:0]      shreg, shreg_nxt;
   logic             miso_q, miso_q_nxt;
   logic             sclk_nxt, mosi_nxt, done_nxt;
   logic [4:0]       ss_n_nxt;
   logic [7:0]       rd_data_nxt;

   // Active-low one-hot select; unknown codes select nobody.
   function automatic logic [4:0] ss_decode(input logic [2:0] s);
      case (s)
         SS_NONE:    ss_decode = 5'b11111;
         SS_CH1:     ss_decode = 5'b11110;
         SS_CH2:     ss_decode = 5'b11101;
         SS_CH3:     ss_decode = 5'b11011;
         SS_TRIGGER: ss_decode = 5'b10111;
         SS_EEPROM:  ss_decode = 5'b01111;
         default:    ss_decode = 5'b11111;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         miso_q  <= 1'b0;
         SCLK    <= 1'b0;
         MOSI    <= 1'b0;
         SS_n    <= 5'b11111;
         done    <= 1'b0;
         rd_data <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         bit_cnt <= bit_cnt_nxt;
         shreg   <= shreg_nxt;
         miso_q  <= miso_q_nxt;
         SCLK    <= sclk_nxt;
         MOSI    <= mosi_nxt;
         SS_n    <= ss_n_nxt;
         done    <= done_nxt;
         rd_data <= rd_data_nxt;
      end
   end

   // shreg[15] always holds the next bit to drive; MISO bits enter at the LSB on each fall.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      bit_cnt_nxt = bit_cnt;
      shreg_nxt   = shreg;
      miso_q_nxt  = miso_q;
      sclk_nxt    = SCLK;
      mosi_nxt    = MOSI;
      ss_n_nxt    = SS_n;
      done_nxt    = 1'b0;
      rd_data_nxt = rd_data;
      case (state)
         IDLE: begin
            if (wrt) begin
               state_nxt   = FRONT;
               cnt_nxt     = '0;
               bit_cnt_nxt = '0;
               shreg_nxt   = {cmd[14:0], 1'b0};
               mosi_nxt    = cmd[15];
               ss_n_nxt    = ss_decode(ss_sel);
            end
         end
         FRONT: begin
            if (cnt == HALF_LAST) begin
               state_nxt  = XFER;
               cnt_nxt    = '0;
               sclk_nxt   = 1'b1;
               miso_q_nxt = MISO;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         XFER: begin
            if (cnt == HALF_LAST) begin
               sclk_nxt    = 1'b0;
               shreg_nxt   = {shreg[14:0], miso_q};
               bit_cnt_nxt = bit_cnt + 4'd1;
               if (bit_cnt != 4'd15) mosi_nxt = shreg[15];
               cnt_nxt     = cnt + CNT_W'(1);
            end else if (cnt == BIT_LAST) begin
               cnt_nxt = '0;
               // Bit counter wrapped on the 16th fall: the low half of the last bit just ended.
               if (bit_cnt == 4'd0) begin
                  state_nxt = BACK;
               end else begin
                  sclk_nxt   = 1'b1;
                  miso_q_nxt = MISO;
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         BACK: begin
            if (cnt == HALF_LAST) begin
               state_nxt   = IDLE;
               cnt_nxt     = '0;
               ss_n_nxt    = 5'b11111;
               rd_data_nxt = shreg[7:0];
               done_nxt    = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef SPI_WRT_ERR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wrt_err <= 1'b0;
      else        wrt_err <= wrt && (state != IDLE);
   end
`endif

endmodule
